// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with next-PC select and optional return-address stack (PC_SEQ_RAS_EN)
module pc_sequencer #(
  parameter int ADDR_W    = 17,
  parameter int RESET_PC  = 0,
  parameter int STEP      = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_one,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_error
);
  logic [ADDR_W-1:0] pc_nxt;
  assign pc_plus_one = pc + ADDR_W'(STEP);
  always_ff @(posedge clock or posedge reset)
    if (reset) pc <= ADDR_W'(RESET_PC);
    else if (enable) pc <= pc_nxt;
`ifdef PC_SEQ_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] ptr, top;
  logic [PW:0] count;
  logic err, replace, push, pop, err_set;
  assign top = ptr - PW'(1);
  assign stack_empty = count == '0;
  assign stack_full = count == (PW+1)'(RAS_DEPTH);
  assign stack_error = err;
  // call+ret on an empty stack degenerates to a plain push
  assign replace = call && ret && !stack_empty;
  assign push = call && !replace;
  assign pop = ret && !call && !stack_empty;
  assign err_set = (ret && !call && stack_empty) || (call && !ret && stack_full);
  assign pc_nxt = call ? branch_target : pop ? ras[top] : (branch_taken && !ret) ? branch_target : pc_plus_one;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else if (enable) begin
      err <= err | err_set;
      if (push) begin
        ptr <= ptr + PW'(1);
        count <= stack_full ? count : count + 1'b1;
      end else if (pop) begin
        ptr <= top;
        count <= count - 1'b1;
      end
    end
  // a full stack wraps ptr onto the oldest entry, so pushing overwrites it
  always_ff @(posedge clock)
    if (enable && (push || replace)) ras[replace ? top : ptr] <= pc_plus_one;
`else
  logic unused_ret;
  assign unused_ret = ret;
  assign pc_nxt = (call || branch_taken) ? branch_target : pc_plus_one;
  assign stack_empty = 1'b1;
  assign stack_full = 1'b0;
  assign stack_error = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench against a queue-based PC/return-stack model
module tb_pc_sequencer;
  localparam int AW = 17;
  localparam int DEPTH = 4;
  typedef logic [2*AW+2:0] exp_t;
  logic clock = 0, reset = 0, enable = 0, branch_taken = 0, call = 0, ret = 0;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] pc, pc_plus_one;
  logic stack_empty, stack_full, stack_error;
  exp_t sb[$];
  exp_t e, got;
  int compared = 0, mismatched = 0;
  logic [AW-1:0] mpc = '0;
  logic [AW-1:0] ras_q[$];
  logic merr = 0;

  pc_sequencer dut (
    .clock(clock), .reset(reset), .enable(enable), .branch_taken(branch_taken),
    .branch_target(branch_target), .call(call), .ret(ret), .pc(pc),
    .pc_plus_one(pc_plus_one), .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_error(stack_error)
  );

  always #5 clock = ~clock;

  function automatic exp_t expv();
    return {mpc, mpc + AW'(1), ras_q.size() == 0, ras_q.size() == DEPTH, merr};
  endfunction

  task automatic step(input logic en, input logic bt, input logic [AW-1:0] tgt, input logic c, input logic r);
    logic [AW-1:0] nxt;
    @(negedge clock);
    enable = en; branch_taken = bt; branch_target = tgt; call = c; ret = r;
    nxt = mpc + AW'(1);
    if (en) begin
`ifdef PC_SEQ_RAS_EN
      if (c && r) begin
        if (ras_q.size() == 0) ras_q.push_back(nxt);
        else ras_q[ras_q.size()-1] = nxt;
        mpc = tgt;
      end else if (r) begin
        if (ras_q.size() != 0) mpc = ras_q.pop_back();
        else begin mpc = nxt; merr = 1; end
      end else if (c) begin
        if (ras_q.size() == DEPTH) begin void'(ras_q.pop_front()); merr = 1; end
        ras_q.push_back(nxt);
        mpc = tgt;
      end else mpc = bt ? tgt : nxt;
`else
      mpc = (c || bt) ? tgt : nxt;
`endif
    end
    sb.push_back(expv());
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    enable = 0; call = 0; ret = 0; branch_taken = 0;
    #2 reset = 1;
    mpc = '0; ras_q.delete(); merr = 0;
    sb.push_back(expv());
    #2 reset = 0;
  endtask

  always @(posedge clock or posedge reset) begin
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      got = {pc, pc_plus_one, stack_empty, stack_full, stack_error};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL state #%0d: got pc=%h ppo=%h empty/full/err=%b%b%b, expected pc=%h ppo=%h empty/full/err=%b%b%b",
                 compared, got[2*AW+2:AW+3], got[AW+2:3], got[2], got[1], got[0],
                 e[2*AW+2:AW+3], e[AW+2:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    logic [AW-1:0] t;
    #1 reset = 1;
    sb.push_back(expv());
    #2 reset = 0;
    repeat (3) step(1, 0, '0, 0, 0);
    step(1, 1, 17'h00005, 0, 0);
    step(1, 1, 17'h00100, 0, 0);
    step(0, 1, 17'h1ABCD, 1, 0);
    step(0, 0, 17'h00001, 0, 1);
    step(1, 1, 17'h00010, 0, 0);
    step(1, 0, 17'h00200, 1, 0);
    step(1, 0, '0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, AW'(17'h01000 + i * 17'h100), 1, 0);
    repeat (5) step(1, 0, '0, 0, 1);
    step(1, 1, 17'h00020, 0, 0);
    step(1, 0, '0, 0, 1);
    step(1, 1, 17'h1FFFF, 0, 0);
    step(1, 0, '0, 0, 0);
    step(1, 0, 17'h00300, 1, 1);
    step(1, 0, 17'h00400, 1, 1);
    step(1, 0, '0, 0, 1);
    pulse_reset();
    step(1, 1, 17'h00040, 0, 0);
    step(1, 0, 17'h00500, 1, 0);
    step(1, 0, 17'h00600, 1, 0);
    pulse_reset();
    step(1, 0, 17'h00700, 1, 0);
    step(0, 0, '0, 0, 0);
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      t = ($urandom_range(0, 7) == 0) ? AW'(17'h1FFFF - $urandom_range(0, 3)) : AW'($urandom);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, t,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    @(negedge clock);
    @(negedge clock);
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expected states never observed, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
